// File: rtl/enqdeq_tkn_exec.sv
`default_nettype none
// ============================================================================
// Module   : enqdeq_tkn_exec
// Brief    : Grant-side executor. Runs the granted channel's ENQ/DEQ on a
//            per-channel ring-queue pointer table and acknowledges the token.
//            Optional refused-op counter: define ENQDEQ_TKN_EXEC_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module enqdeq_tkn_exec #(
   parameter int N     = 16,
   parameter int PTR_W = 8
) (
   input  logic             user_clk,
   input  logic             reset_n,
   input  logic [N-1:0]     tkn,
   input  logic [N-1:0]     req_enq,
   input  logic [N-1:0]     qclr,
   output logic             tkn_ack,
   output logic [N-1:0]     done,
   output logic             done_ok,
   output logic [PTR_W-1:0] done_ptr,
   output logic             tkn_err,
   output logic [15:0]      fail_cnt
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [PTR_W:0] c_full_cnt = {1'b1, {PTR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOOK = 2'd1,
      S_UPD  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               op_q, op_d;
   logic [PTR_W-1:0]   lk_head_q, lk_head_d;
   logic [PTR_W-1:0]   lk_tail_q, lk_tail_d;
   logic [PTR_W:0]     lk_cnt_q, lk_cnt_d;
   logic               tkn_ack_q, tkn_ack_d;
   logic [N-1:0]       done_q, done_d;
   logic               ok_q, ok_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               tkn_err_q, tkn_err_d;

   logic [PTR_W-1:0]   head_q [N];
   logic [PTR_W-1:0]   head_d [N];
   logic [PTR_W-1:0]   tail_q [N];
   logic [PTR_W-1:0]   tail_d [N];
   logic [PTR_W:0]     cnt_q  [N];
   logic [PTR_W:0]     cnt_d  [N];

   logic [IDX_W-1:0]   low_idx;
   logic               multi_tkn;

   always_comb begin
      low_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (tkn[k]) low_idx = IDX_W'(k);
      end
      multi_tkn = (tkn & (tkn - N'(1))) != '0;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_d      = op_q;
      lk_head_d = lk_head_q;
      lk_tail_d = lk_tail_q;
      lk_cnt_d  = lk_cnt_q;
      tkn_ack_d = 1'b0;
      done_d    = '0;
      ok_d      = 1'b0;
      ptr_d     = '0;
      tkn_err_d = tkn_err_q;
      for (int k = 0; k < N; k++) begin
         head_d[k] = head_q[k];
         tail_d[k] = tail_q[k];
         cnt_d[k]  = cnt_q[k];
      end

      case (state_q)
         S_IDLE: begin
            if (|tkn) begin
               idx_d   = low_idx;
               op_d    = req_enq[low_idx];
               state_d = S_LOOK;
               if (multi_tkn) tkn_err_d = 1'b1;
            end
         end
         S_LOOK: begin
            // A clear landing now must be seen by the update as an empty queue
            if (qclr[idx_q]) begin
               lk_head_d = '0;
               lk_tail_d = '0;
               lk_cnt_d  = '0;
            end else begin
               lk_head_d = head_q[idx_q];
               lk_tail_d = tail_q[idx_q];
               lk_cnt_d  = cnt_q[idx_q];
            end
            tkn_ack_d = 1'b1;
            state_d   = S_UPD;
         end
         S_UPD: begin
            if (!qclr[idx_q]) begin
               if (op_q && (lk_cnt_q != c_full_cnt)) begin
                  ok_d          = 1'b1;
                  ptr_d         = lk_tail_q;
                  tail_d[idx_q] = lk_tail_q + PTR_W'(1);
                  cnt_d[idx_q]  = lk_cnt_q + (PTR_W+1)'(1);
               end else if (!op_q && (lk_cnt_q != '0)) begin
                  ok_d          = 1'b1;
                  ptr_d         = lk_head_q;
                  head_d[idx_q] = lk_head_q + PTR_W'(1);
                  cnt_d[idx_q]  = lk_cnt_q - (PTR_W+1)'(1);
               end
            end
            done_d[idx_q] = 1'b1;
            state_d       = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      for (int k = 0; k < N; k++) begin
         if (qclr[k]) begin
            head_d[k] = '0;
            tail_d[k] = '0;
            cnt_d[k]  = '0;
         end
      end
   end

   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         op_q      <= 1'b0;
         lk_head_q <= '0;
         lk_tail_q <= '0;
         lk_cnt_q  <= '0;
         tkn_ack_q <= 1'b0;
         done_q    <= '0;
         ok_q      <= 1'b0;
         ptr_q     <= '0;
         tkn_err_q <= 1'b0;
         for (int k = 0; k < N; k++) begin
            head_q[k] <= '0;
            tail_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         op_q      <= op_d;
         lk_head_q <= lk_head_d;
         lk_tail_q <= lk_tail_d;
         lk_cnt_q  <= lk_cnt_d;
         tkn_ack_q <= tkn_ack_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         ptr_q     <= ptr_d;
         tkn_err_q <= tkn_err_d;
         for (int k = 0; k < N; k++) begin
            head_q[k] <= head_d[k];
            tail_q[k] <= tail_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
      end
   end

   assign tkn_ack  = tkn_ack_q;
   assign done     = done_q;
   assign done_ok  = ok_q;
   assign done_ptr = ptr_q;
   assign tkn_err  = tkn_err_q;

`ifdef ENQDEQ_TKN_EXEC_STAT_EN
   logic [15:0] fail_cnt_q, fail_cnt_d;

   always_comb begin
      fail_cnt_d = fail_cnt_q;
      if ((state_q == S_RESP) && !ok_q && (fail_cnt_q != 16'hFFFF))
         fail_cnt_d = fail_cnt_q + 16'd1;
   end

   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) fail_cnt_q <= '0;
      else          fail_cnt_q <= fail_cnt_d;
   end

   assign fail_cnt = fail_cnt_q;
`else
   assign fail_cnt = 16'h0;
`endif

endmodule
`default_nettype wire
